// File: rtl/scr_pkg.sv
// Shared types, default constants and single-step LFSR helper for the additive scrambler.
package scr_pkg;

    localparam int unsigned LFSR_W_DEF = 12;
    localparam logic [11:0] TAPS_DEF   = 12'h829;
    localparam logic [11:0] SEED_DEF   = 12'h89F;

    // Widest LFSR the step helper handles; narrower registers are zero-extended.
    localparam int unsigned LFSR_W_MAX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [LFSR_W_MAX-1:0] state;
        logic                  fb;
    } lfsr_step_t;

    // Fibonacci step: feedback is the parity of tapped bits, shifted in at bit 0.
    function automatic lfsr_step_t lfsr_step(input logic [LFSR_W_MAX-1:0] state,
                                             input logic [LFSR_W_MAX-1:0] taps);
        lfsr_step_t r;
        r.fb    = ^(state & taps);
        r.state = {state[LFSR_W_MAX-2:0], r.fb};
        return r;
    endfunction

endpackage

// File: rtl/lfsr_keygen.sv
// Combinational unroll of DATA_W LFSR steps: key bit k is the feedback of step k.
module lfsr_keygen
    import scr_pkg::*;
#(
    parameter int unsigned       LFSR_W = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEF),
    parameter int unsigned       DATA_W = 1
) (
    input  logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] state_next,
    output logic [DATA_W-1:0] key
);

    localparam logic [LFSR_W_MAX-1:0] TAPS_EXT = LFSR_W_MAX'(TAPS);

    lfsr_step_t            step;
    logic [LFSR_W_MAX-1:0] cur;

    // Bits above LFSR_W never reach the feedback because TAPS_EXT is zero there.
    always_comb begin
        cur  = LFSR_W_MAX'(state);
        step = '0;
        key  = '0;
        for (int k = 0; k < DATA_W; k++) begin
            step   = lfsr_step(cur, TAPS_EXT);
            key[k] = step.fb;
            cur    = step.state;
        end
        state_next = cur[LFSR_W-1:0];
    end

endmodule

// File: rtl/lfsr_scrambler.sv
// Framed additive LFSR scrambler/descrambler with valid/ready streaming and per-frame reseed.
// Optional macro SCR_SEED_LOAD_EN adds a seed_val port sampled on an accepted start.
module lfsr_scrambler
    import scr_pkg::*;
#(
    parameter int unsigned       LFSR_W    = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(TAPS_DEF),
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(SEED_DEF),
    parameter int unsigned       DATA_W    = 1,
    parameter int unsigned       FRAME_LEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef SCR_SEED_LOAD_EN
    ,
    input  logic [LFSR_W-1:0] seed_val
`endif
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t            state, state_next;
    logic [LFSR_W-1:0] lfsr, lfsr_next, lfsr_adv, seed_sel;
    logic [CNT_W-1:0]  count, count_next;
    logic [DATA_W-1:0] key, out_data_next;
    logic              out_valid_next, out_last_next;
    logic              accept, last_beat;

    lfsr_keygen #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .DATA_W (DATA_W)
    ) u_keygen (
        .state      (lfsr),
        .state_next (lfsr_adv),
        .key        (key)
    );

`ifdef SCR_SEED_LOAD_EN
    // An all-zero LFSR would lock up, so a zero seed falls back to SEED.
    assign seed_sel = (seed_val == '0) ? SEED : seed_val;
`else
    assign seed_sel = SEED;
`endif

    assign busy      = (state == RUN);
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_beat = (count == LAST_CNT);
    assign done      = (state == DRAIN) && out_valid && out_ready && out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        lfsr_next      = lfsr;
        count_next     = count;
        out_data_next  = out_data;
        out_valid_next = out_valid;
        out_last_next  = out_last;

        if (out_valid && out_ready) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    lfsr_next  = seed_sel;
                    count_next = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    out_data_next  = in_data ^ key;
                    out_valid_next = 1'b1;
                    out_last_next  = last_beat;
                    lfsr_next      = lfsr_adv;
                    count_next     = count + CNT_W'(1);
                    if (last_beat) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: keystream state, beat counter and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= SEED;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            lfsr      <= lfsr_next;
            count     <= count_next;
            out_data  <= out_data_next;
            out_valid <= out_valid_next;
            out_last  <= out_last_next;
        end
    end

endmodule

// File: tb/tb_lfsr_scrambler.sv
// Directed bench for lfsr_scrambler: keystream, backpressure, abort, framing, DATA_W=4, FRAME_LEN=1, TX->RX loop.
module tb_lfsr_scrambler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Default instance under direct control
    logic a_start, a_busy, a_done, a_in_valid, a_in_ready, a_in_data;
    logic a_out_valid, a_out_ready, a_out_data, a_out_last;
    logic [11:0] a_seed;
    // DATA_W=4, FRAME_LEN=2
    logic b_start, b_busy, b_done, b_in_valid, b_in_ready;
    logic b_out_valid, b_out_ready, b_out_last;
    logic [3:0] b_in_data, b_out_data;
    // FRAME_LEN=1
    logic c_start, c_busy, c_done, c_in_valid, c_in_ready, c_in_data;
    logic c_out_valid, c_out_ready, c_out_data, c_out_last;
    // TX feeding RX
    logic tx_start, tx_busy, tx_done, tx_in_valid, tx_in_ready, tx_in_data;
    logic tx_out_valid, tx_out_data, tx_out_last;
    logic rx_start, rx_busy, rx_done, rx_in_ready;
    logic rx_out_valid, rx_out_ready, rx_out_data, rx_out_last;

    lfsr_scrambler u_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last)
`ifdef SCR_SEED_LOAD_EN
        , .seed_val(a_seed)
`endif
    );

    lfsr_scrambler #(.DATA_W(4), .FRAME_LEN(2)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last)
`ifdef SCR_SEED_LOAD_EN
        , .seed_val(12'h000)
`endif
    );

    lfsr_scrambler #(.FRAME_LEN(1)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_last(c_out_last)
`ifdef SCR_SEED_LOAD_EN
        , .seed_val(12'h000)
`endif
    );

    lfsr_scrambler u_tx (
        .clk(clk), .rst(rst), .start(tx_start), .busy(tx_busy), .done(tx_done),
        .in_valid(tx_in_valid), .in_ready(tx_in_ready), .in_data(tx_in_data),
        .out_valid(tx_out_valid), .out_ready(rx_in_ready), .out_data(tx_out_data),
        .out_last(tx_out_last)
`ifdef SCR_SEED_LOAD_EN
        , .seed_val(12'h000)
`endif
    );

    lfsr_scrambler u_rx (
        .clk(clk), .rst(rst), .start(rx_start), .busy(rx_busy), .done(rx_done),
        .in_valid(tx_out_valid), .in_ready(rx_in_ready), .in_data(tx_out_data),
        .out_valid(rx_out_valid), .out_ready(rx_out_ready), .out_data(rx_out_data),
        .out_last(rx_out_last)
`ifdef SCR_SEED_LOAD_EN
        , .seed_val(12'h000)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Pulse counters and RX capture
    int          a_done_n = 0, tx_done_n = 0, rx_done_n = 0, rx_n = 0, rx_last_idx = -1;
    logic [31:0] rx_word = '0;
    always @(posedge clk) begin
        if (a_done)  a_done_n  <= a_done_n + 1;
        if (tx_done) tx_done_n <= tx_done_n + 1;
        if (rx_done) rx_done_n <= rx_done_n + 1;
        if (!rst && rx_out_valid && rx_out_ready) begin
            if (rx_n < 32) rx_word[rx_n[4:0]] <= rx_out_data;
            if (rx_out_last) rx_last_idx <= rx_n;
            rx_n <= rx_n + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    logic        ka [0:63];
    logic [11:0] s;
    logic [4:0]  hand;
    logic [31:0] w;
    int          tx_stall;

    initial begin
        // Reference keystream from x^12+x^6+x^4+x+1 written as explicit taps
        s = 12'h89F;
        for (int i = 0; i < 64; i++) begin
            ka[i] = s[11] ^ s[5] ^ s[3] ^ s[0];
            s = {s[10:0], ka[i]};
        end
        hand = 5'b01111;  // keys 0..4 = 1,1,1,1,0

        rst = 1'b1;
        a_start = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 1; a_seed = 12'h000;
        b_start = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 1;
        c_start = 0; c_in_valid = 0; c_in_data = 0; c_out_ready = 1;
        tx_start = 0; rx_start = 0; tx_in_valid = 0; tx_in_data = 0; rx_out_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",      32'(a_busy), 0);
        check("rst_done",      32'(a_done), 0);
        check("rst_out_valid", 32'(a_out_valid), 0);
        check("rst_out_data",  32'(a_out_data), 0);
        check("rst_out_last",  32'(a_out_last), 0);
        check("rst_in_ready",  32'(a_in_ready), 0);

        // First frame: 5 zero beats, then stall, then abort by reset
        @(negedge clk); rst = 0; a_start = 1;
        @(negedge clk); a_start = 0; a_in_valid = 1; a_in_data = 0; #1;
        check("busy_run", 32'(a_busy), 1);
        check("first_latency", 32'(a_out_valid), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("zero_valid", 32'(a_out_valid), 1);
            check("zero_key",   32'(a_out_data), 32'(hand[k]));
        end
        a_out_ready = 0; a_in_data = 1; #1;
        check("stall_in_ready", 32'(a_in_ready), 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); #1;
            check("stall_valid", 32'(a_out_valid), 1);
            check("stall_hold",  32'(a_out_data), 0);
            check("stall_ready", 32'(a_in_ready), 0);
        end
        a_out_ready = 1;
        for (int k = 5; k < 10; k++) begin
            @(negedge clk); #1;
            check("release_key", 32'(a_out_data), 32'(1'b1 ^ ka[k]));
        end
        rst = 1; a_in_valid = 0;
        @(negedge clk); #1;
        check("abort_busy",    32'(a_busy), 0);
        check("abort_valid",   32'(a_out_valid), 0);
        check("abort_no_done", 32'(a_done_n), 0);

        // Restart: full frame, start pulsed mid-run and in the done cycle
        rst = 0; a_start = 1;
        @(negedge clk); a_start = 0; a_in_valid = 1; a_in_data = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk); #1;
            check("frame_key",  32'(a_out_data), (k < 5) ? 32'(hand[k]) : 32'(ka[k]));
            check("frame_last", 32'(a_out_last), (k == 31) ? 1 : 0);
            a_start = (k == 10);
        end
        check("done_pulse", 32'(a_done), 1);
        check("drain_in_ready", 32'(a_in_ready), 0);
        a_start = 1; a_in_valid = 0;
        @(negedge clk); a_start = 0; #1;
        check("idle_busy",   32'(a_busy), 0);
        check("idle_valid",  32'(a_out_valid), 0);
        check("done_once",   32'(a_done_n), 1);
        check("done_clear",  32'(a_done), 0);

`ifdef SCR_SEED_LOAD_EN
        // seed 0x001 gives keys 1,1,1,0; zero seed falls back to SEED (4th key 1)
        @(negedge clk); a_seed = 12'h001; a_start = 1;
        @(negedge clk); a_start = 0; a_seed = 12'h000; a_in_valid = 1; a_in_data = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("seed1_key", 32'(a_out_data), (k == 3) ? 0 : 1);
        end
        rst = 1; a_in_valid = 0;
        @(negedge clk); rst = 0; a_start = 1;
        @(negedge clk); a_start = 0; a_in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("seed0_key", 32'(a_out_data), 32'(hand[k]));
        end
        rst = 1; a_in_valid = 0;
        @(negedge clk); rst = 0;
`endif

        // DATA_W=4: beat 0 = keys 0..3, beat 1 = keys 4..7 (bit 0 earliest)
        @(negedge clk); b_start = 1;
        @(negedge clk); b_start = 0; b_in_valid = 1; b_in_data = 4'h0;
        @(negedge clk); #1;
        check("w4_beat0", 32'(b_out_data), 32'h0000000F);
        @(negedge clk); #1;
        check("w4_beat1",  32'(b_out_data), 32'h00000008);
        check("w4_last",   32'(b_out_last), 1);
        check("w4_done",   32'(b_done), 1);
        b_in_valid = 0;
        @(negedge clk); #1;
        check("w4_idle", 32'(b_busy), 0);

        // FRAME_LEN=1: single accept goes straight to DRAIN
        @(negedge clk); c_start = 1;
        @(negedge clk); c_start = 0; c_in_valid = 1; c_in_data = 1;
        @(negedge clk); #1;
        check("f1_data", 32'(c_out_data), 0);
        check("f1_last", 32'(c_out_last), 1);
        check("f1_busy", 32'(c_busy), 0);
        check("f1_done", 32'(c_done), 1);
        c_in_valid = 0;
        @(negedge clk); #1;
        check("f1_valid_clear", 32'(c_out_valid), 0);

        // TX -> RX round trip on random data
        w = $urandom();
        tx_stall = 0;
        @(negedge clk); tx_start = 1; rx_start = 1;
        @(negedge clk); tx_start = 0; rx_start = 0; tx_in_valid = 1;
        for (int k = 0; k < 32; k++) begin
            tx_in_data = w[k];
            #1;
            if (!tx_in_ready) tx_stall++;
            @(negedge clk);
        end
        tx_in_valid = 0;
        for (int t = 0; t < 20 && !(rx_n >= 32 && rx_done_n >= 1); t++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        check("loop_no_stall", 32'(tx_stall), 0);
        check("loop_count",    32'(rx_n), 32);
        check("loop_data",     rx_word, w);
        check("loop_last_idx", 32'(rx_last_idx), 31);
        check("loop_tx_done",  32'(tx_done_n), 1);
        check("loop_rx_done",  32'(rx_done_n), 1);
        check("loop_tx_busy",  32'(tx_busy), 0);
        check("loop_rx_busy",  32'(rx_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
